// File: rtl/pow_iter_unit.sv
// Iterative fixed-point power unit: raises a signed Q-format base to a small
// unsigned integer exponent with one saturating multiply per clock.
module pow_iter_unit #(
    parameter int WIDTH = 32,
    parameter int Q     = 15,
    parameter int EXP_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] data_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [WIDTH-1:0] ONE =
        {{(WIDTH-1){1'b0}}, 1'b1} << Q;
    localparam logic signed [2*WIDTH-1:0] SMAX =
        {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SMIN =
        {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t                    state;
    logic signed [WIDTH-1:0]   x_reg;
    logic signed [WIDTH-1:0]   acc;
    logic [EXP_W-1:0]          cnt;
    logic                      ovf;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;
    logic signed [WIDTH-1:0]   step_val;
    logic                      step_clamp;

    function automatic logic sat_hit(input logic signed [2*WIDTH-1:0] v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_val(
        input logic signed [2*WIDTH-1:0] v
    );
        if (v > SMAX) begin
            return SMAX[WIDTH-1:0];
        end else if (v < SMIN) begin
            return SMIN[WIDTH-1:0];
        end
        return v[WIDTH-1:0];
    endfunction

    // Both operands are sign-extended so the product is the exact 2*WIDTH
    // result; >>> floors toward minus infinity.
    assign prod       = $signed({{WIDTH{acc[WIDTH-1]}}, acc}) *
                        $signed({{WIDTH{x_reg[WIDTH-1]}}, x_reg});
    assign shifted    = prod >>> Q;
    assign step_val   = sat_val(shifted);
    assign step_clamp = sat_hit(shifted);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            overflow  <= 1'b0;
            x_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg    <= data_in;
                        cnt      <= exp_in;
                        acc      <= ONE;
                        ovf      <= 1'b0;
                        in_ready <= 1'b0;
                        if (exp_in == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            data_out  <= ONE;
                            overflow  <= 1'b0;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc <= step_val;
                    ovf <= ovf | step_clamp;
                    cnt <= cnt - 1'b1;
                    // The result registers load on the final multiply so
                    // they stay frozen through DONE and the following IDLE.
                    if (cnt == EXP_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        data_out  <= step_val;
                        overflow  <= ovf | step_clamp;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/pow_iter_unit.md
POW_ITER_UNIT -- requirements
Module: pow_iter_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width in bits (signed two's complement).
REQ-002 SHALL have parameter Q, default 15, meaning fractional bits, legal range 0..WIDTH-2.
REQ-003 SHALL have parameter EXP_W, default 4, meaning exponent width; the largest exponent is 2^EXP_W-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port data_in, input, WIDTH bits: signed Q-format base x.
REQ-007 SHALL have port exp_in, input, EXP_W bits: unsigned integer exponent n.
REQ-008 SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the unit can accept an operand pair.
REQ-010 SHALL have port data_out, output, WIDTH bits: signed Q-format result x^n.
REQ-011 SHALL have port out_valid, output, 1 bit: data_out and overflow are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port overflow, output, 1 bit: saturation occurred at any step of this result.

Function
REQ-014 SHALL implement the states IDLE, MUL and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 Accept: in IDLE with in_valid=1, the unit SHALL on that edge (E0) latch x and set cnt=n, acc=ONE (ONE = 1<<Q) and sticky ovf=0, then go to MUL if n>0, otherwise to DONE.
REQ-016 MUL step: on each edge the unit SHALL compute acc = sat((acc*x) >>> Q) using a full 2*WIDTH signed product and an arithmetic shift (truncation toward minus infinity), then decrement cnt.
REQ-017 sat SHALL clamp to 2^(WIDTH-1)-1 above and to -2^(WIDTH-1) below, and SHALL set ovf=1 whenever a clamp is applied.
REQ-018 The unit SHALL leave MUL for DONE on the edge that performs the n-th multiply, so out_valid is first high after edge E0+n (n=0 gives after E0).
REQ-019 In DONE, data_out=acc and overflow=ovf SHALL be held stable while out_ready=0; with out_ready=1 the unit SHALL go to IDLE on that edge, and out_valid SHALL fall.
REQ-020 No accept SHALL occur in the same cycle as a result handoff; the minimum interval between accepts is n+2 cycles.
REQ-021 in_valid, data_in and exp_in SHALL be ignored outside IDLE; a change in operands during MUL SHALL NOT affect the result.
REQ-022 Once set, ovf SHALL stay set for the remainder of the operation, even if later steps do not saturate.
REQ-023 data_out and overflow SHALL keep their last values after a handoff until the next DONE updates them.

Reset
REQ-024 With rst=1 at an edge, the unit SHALL go to IDLE and clear data_out=0, overflow=0, out_valid=0, acc=0 and cnt=0; after reset, in_ready=1.
REQ-025 Reset SHALL take priority over in_valid and out_ready and SHALL abort any operation in MUL or DONE with no result emitted.
REQ-026 The first accept SHALL be possible on the first edge with rst=0.

Verification (WIDTH=32, Q=15)
REQ-027 Input x=16384 (0.5), n=2, out_ready=1 -> out_valid after edge E0+2, data_out=8192, overflow=0.
REQ-028 Input x=-49152 (-1.5), n=3 -> intermediate results -49152, 73728 and -110592; final data_out=-110592, overflow=0.
REQ-029 Input x=12345, n=0 -> out_valid after edge E0, data_out=32768, overflow=0.
REQ-030 Input x=6553600 (200.0), n=3 -> data_out=0x7FFFFFFF, overflow=1; with x=-6553600, n=3 -> data_out=0x80000000, overflow=1.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, data_out and overflow stay stable and in_ready=0 with in_valid held at 1; release out_ready -> IDLE on the next edge, and the next pair is accepted one edge later.
REQ-032 Reset mid-operation: rst=1 for 1 cycle while in MUL (n=15) -> no out_valid pulse, all outputs 0, in_ready=1 on the next cycle; a fresh x=32768, n=15 then returns 32768.
